// File: rtl/wb_req_arbiter_if.sv
// Command port between wb_req_arbiter and the Wishbone master wrapper.
// master = arbiter side, slave = wrapper side.
interface wb_req_arbiter_if #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32
);
  logic                m_wr_o;
  logic                m_en_o;
  logic [ADDR_WID-1:0] m_addr_o;
  logic [DATA_WID-1:0] m_dout_o;
  logic [DATA_WID-1:0] m_din_i;
  logic                m_valid_i;

  modport master (
    output m_wr_o, m_en_o, m_addr_o, m_dout_o,
    input  m_din_i, m_valid_i
  );

  modport slave (
    input  m_wr_o, m_en_o, m_addr_o, m_dout_o,
    output m_din_i, m_valid_i
  );
endinterface

// File: rtl/wb_req_arbiter.sv
// Shares one Wishbone master wrapper between NREQ requesters, one command at a time.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module wb_req_arbiter #(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32,
  parameter int NREQ     = 2
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          wr_i,
  input  logic [NREQ*ADDR_WID-1:0] addr_i,
  input  logic [NREQ*DATA_WID-1:0] wdata_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic [DATA_WID-1:0]      rdata_o,
  output logic                     busy_o,
  output logic [1:0]               state_o,
  wb_req_arbiter_if.master         m_bus
);

  // Handshake: a requester raises req_i and holds it (with its command) until
  // its done_o pulse; the command is sampled only in the grant cycle, and the
  // wrapper side is a single-cycle m_en_o pulse answered later by m_valid_i.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_done;
  logic [DATA_WID-1:0] r_rdata;
  logic                r_busy;
  logic                r_en;
  logic                r_wr;
  logic [ADDR_WID-1:0] r_addr;
  logic [DATA_WID-1:0] r_dout;

  logic                w_found;
  logic [PW-1:0]       w_win_idx;
  logic [NREQ-1:0]     w_win_oh;
  logic [NREQ-1:0]     w_gnt_nxt;
  logic [NREQ-1:0]     w_done_nxt;
  logic                w_busy_nxt;
  logic                w_en_nxt;
  logic                w_grant;

`ifdef WB_ARB_RR_EN
  localparam int CW = PW + 1;
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] w_cand;

  // Scan upward from the pointer with wrap-around; first requester found wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = {1'b0, r_ptr} + CW'(i);
      if (w_cand >= CW'(NREQ)) w_cand = w_cand - CW'(NREQ);
      if (!w_found && req_i[w_cand[PW-1:0]]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
    end
  end
`else
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req_i[PW'(i)]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = 1'b1;
  end

  assign w_grant = (r_state == S_IDLE) && w_found;

  // State register plus the registered outputs and command/data latches.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_en    <= w_en_nxt;
      if (w_grant) begin
        r_wr   <= wr_i[w_win_idx];
        r_addr <= addr_i[w_win_idx*ADDR_WID +: ADDR_WID];
        r_dout <= wdata_i[w_win_idx*DATA_WID +: DATA_WID];
      end
      if (r_state == S_WAIT && m_bus.m_valid_i) begin
        r_rdata <= m_bus.m_din_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (m_bus.m_valid_i) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in that state.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_en_nxt   = (w_state_nxt == S_ISSUE);
    w_done_nxt = (w_state_nxt == S_GAP) ? r_gnt : '0;
    if (w_grant)
      w_gnt_nxt = w_win_oh;
    else if (w_state_nxt == S_IDLE)
      w_gnt_nxt = '0;
    else
      w_gnt_nxt = r_gnt;
  end

  assign gnt_o          = r_gnt;
  assign done_o         = r_done;
  assign rdata_o        = r_rdata;
  assign busy_o         = r_busy;
  assign state_o        = r_state;
  assign m_bus.m_wr_o   = r_wr;
  assign m_bus.m_en_o   = r_en;
  assign m_bus.m_addr_o = r_addr;
  assign m_bus.m_dout_o = r_dout;

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Directed bench for wb_req_arbiter: single read/write, contention order,
// command change after grant, reset mid-transaction and stray valid.
module tb_wb_req_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;

  // clock / reset
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req;
  logic [NR-1:0]    wr;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic [DW-1:0]    rdata;
  logic             busy;
  logic [1:0]       state;

  wb_req_arbiter_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus ();

  wb_req_arbiter #(.ADDR_WID(AW), .DATA_WID(DW), .NREQ(NR)) dut (
    .clk_i   (clk),
    .nrst_i  (nrst),
    .req_i   (req),
    .wr_i    (wr),
    .addr_i  (addr),
    .wdata_i (wdata),
    .gnt_o   (gnt),
    .done_o  (done),
    .rdata_o (rdata),
    .busy_o  (busy),
    .state_o (state),
    .m_bus   (bus)
  );

  // scoreboard
  int            n_total = 0;
  int            n_bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".gnt"},   64'(gnt),          64'(0));
    check({tag, ".done"},  64'(done),         64'(0));
    check({tag, ".busy"},  64'(busy),         64'(0));
    check({tag, ".en"},    64'(bus.m_en_o),   64'(0));
    check({tag, ".wr"},    64'(bus.m_wr_o),   64'(0));
    check({tag, ".addr"},  64'(bus.m_addr_o), 64'(0));
    check({tag, ".dout"},  64'(bus.m_dout_o), 64'(0));
    check({tag, ".rdata"}, 64'(rdata),        64'(0));
    check({tag, ".state"}, 64'(state),        64'(0));
  endtask

  // drivers
  task automatic reset_dut();
    nrst = 1'b0;
    req = '0; wr = '0; addr = '0; wdata = '0;
    bus.m_valid_i = 1'b0;
    bus.m_din_i   = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
  endtask

  // Entry: at a negedge with the request already driven and the DUT idle.
  // Wrapper model: lat idle WAIT cycles, then valid with din.
  task automatic run_txn(input int owner, input logic [AW-1:0] exp_addr, input logic exp_wr,
                         input logic [DW-1:0] exp_dout, input logic [DW-1:0] din, input int lat,
                         input bit drop, input bit mutate, input string tag);
    logic [NR-1:0] oh;
    oh = '0;
    oh[owner] = 1'b1;
    exp_q.push_back(din);
    @(negedge clk);
    check({tag, ".gnt"},  64'(gnt),          64'(oh));
    check({tag, ".en"},   64'(bus.m_en_o),   64'(1));
    check({tag, ".busy"}, 64'(busy),         64'(1));
    check({tag, ".addr"}, 64'(bus.m_addr_o), 64'(exp_addr));
    check({tag, ".wr"},   64'(bus.m_wr_o),   64'(exp_wr));
    if (exp_wr) check({tag, ".dout"}, 64'(bus.m_dout_o), 64'(exp_dout));
    @(negedge clk);
    check({tag, ".en_off"}, 64'(bus.m_en_o), 64'(0));
    check({tag, ".wait"},   64'(state),      64'(2));
    if (mutate) begin
      addr[AW-1:0]  = 32'h0000_0099;
      wdata[DW-1:0] = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < lat; i++) begin
      check({tag, ".nodone"}, 64'(done), 64'(0));
      @(negedge clk);
    end
    bus.m_valid_i = 1'b1;
    bus.m_din_i   = din;
    @(negedge clk);
    bus.m_valid_i = 1'b0;
    bus.m_din_i   = '0;
    check({tag, ".done"},     64'(done),         64'(oh));
    check({tag, ".rdata"},    64'(rdata),        64'(exp_q.pop_front()));
    check({tag, ".gnt_gap"},  64'(gnt),          64'(oh));
    check({tag, ".busy_gap"}, 64'(busy),         64'(1));
    check({tag, ".addr_gap"}, 64'(bus.m_addr_o), 64'(exp_addr));
    if (drop) req[owner] = 1'b0;
    @(negedge clk);
    check({tag, ".done_off"}, 64'(done),         64'(0));
    check({tag, ".busy_off"}, 64'(busy),         64'(0));
    check({tag, ".gnt_off"},  64'(gnt),          64'(0));
    check({tag, ".addr_hold"},64'(bus.m_addr_o), 64'(exp_addr));
  endtask

  initial begin
    reset_dut();

    // single read by requester 0
    wr = 2'b00; addr[AW-1:0] = 32'h10; req = 2'b01;
    run_txn(0, 32'h10, 1'b0, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, "rd");

    // single write by requester 1
    wr = 2'b10; addr[2*AW-1:AW] = 32'h24; wdata[2*DW-1:DW] = 32'hCAFE_0001; req = 2'b10;
    run_txn(1, 32'h24, 1'b1, 32'hCAFE_0001, 32'h0000_A5A5, 1, 1'b1, 1'b0, "wr");
    @(negedge clk);
    check("wr.once", 64'(done), 64'(0));

    // command change after grant must not disturb the in-flight transaction
    wr = 2'b00; addr[AW-1:0] = 32'h10; req = 2'b01;
    run_txn(0, 32'h10, 1'b0, 32'h0, 32'h1111_2222, 2, 1'b1, 1'b1, "chg");

    // stray valid while idle
    bus.m_valid_i = 1'b1;
    bus.m_din_i   = 32'h1234_5678;
    @(negedge clk);
    bus.m_valid_i = 1'b0;
    bus.m_din_i   = '0;
    check("stray.done",  64'(done),  64'(0));
    check("stray.rdata", 64'(rdata), 64'(32'h1111_2222));
    check("stray.state", 64'(state), 64'(0));
    @(negedge clk);
    check("stray.done2", 64'(done),  64'(0));

    // reset while waiting for the wrapper
    addr[AW-1:0] = 32'h40; req = 2'b01;
    @(negedge clk);
    check("rst.gnt", 64'(gnt), 64'(1));
    @(negedge clk);
    check("rst.wait", 64'(state), 64'(2));
    nrst = 1'b0;
    req  = 2'b00;
    @(negedge clk);
    check_reset_vals("rst_mid");
    nrst = 1'b1;
    @(negedge clk);
    check("rst.nodone", 64'(done),  64'(0));
    check("rst.idle",   64'(state), 64'(0));
    addr[AW-1:0] = 32'h44; req = 2'b01;
    run_txn(0, 32'h44, 1'b0, 32'h0, 32'h5555_AAAA, 0, 1'b1, 1'b0, "post");

    // contention: both requesters held for four transactions
    reset_dut();
    addr[AW-1:0] = 32'h100; addr[2*AW-1:AW] = 32'h200; wr = 2'b00; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int owner;
`ifdef WB_ARB_RR_EN
      owner = k % 2;
`else
      owner = 0;
`endif
      run_txn(owner, (owner == 1) ? 32'h200 : 32'h100, 1'b0, 32'h0,
              32'hC000_0000 + 32'(k), 0, 1'b0, 1'b0, $sformatf("cont%0d", k));
    end
    req = 2'b00;
    @(negedge clk);
    check("cont.idle_busy", 64'(busy), 64'(0));
    check("cont.idle_gnt",  64'(gnt),  64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
